// File: rtl/nios_setup_nios2e_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug-memory (ocimem) stage.
// - host_state_e : host-side access FSM states
// - JDO_*        : bit positions of the fields carried in the 38-bit jdo word
package nios_setup_nios2e_cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_CAP  = 2'd2,
        ST_WR      = 2'd3
    } host_state_e;

    localparam int DATA_W        = 32;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_CLR_ERR   = 35;
    localparam int JDO_CLR_RDY   = 34;

endpackage

// File: rtl/nios_setup_nios2e_cpu_debug_ram.sv
// Single-port 32-bit synchronous RAM with a registered (1-cycle) read.
// Ports:
//   clk   - clock
//   we    - write enable, write lands at the rising edge
//   addr  - word address, used for both read and write
//   wdata - write data
//   q     - read data of the address presented one edge earlier
// Contents are not reset and not preloaded.
module nios_setup_nios2e_cpu_debug_ram
    import nios_setup_nios2e_cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q_q <= mem[addr];
    end

    assign q = q_q;

endmodule

// File: rtl/nios_setup_nios2e_cpu_debug_ocimem.sv
// Debug-memory stage shared between the JTAG host (via take_* pulses and jdo)
// and the CPU (simple slave port with waitrequest).
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   jdo, take_*                       - host command word and 1-cycle command pulses
//   cpu_address/read/write/writedata  - CPU request
//   cpu_readdata/readdatavalid        - CPU read response, 2 edges after acceptance
//   cpu_waitrequest                   - CPU request not accepted this cycle
//   MonDReg, monitor_ready, monitor_error - host read data and status
module nios_setup_nios2e_cpu_debug_ocimem
    import nios_setup_nios2e_cpu_debug_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    // Only the "no preload" RAM flavour exists; INIT_ZERO=0 is reserved.
    if (INIT_ZERO == 1'b0) begin : g_init_reserved
    end

    host_state_e       state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rdv_q, rdv_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;

    logic any_take, host_idle, cpu_req, cpu_grant;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign any_take  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign host_idle = (state_q == ST_IDLE);
    assign cpu_req   = cpu_read | cpu_write;
    // Host pulses win any same-cycle collision, so the RAM port stays single-owner.
    assign cpu_grant = cpu_req & host_idle & ~any_take;
    assign cpu_waitrequest = cpu_req & ~cpu_grant;

    always_comb begin
        state_d   = state_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        wdata_d   = wdata_q;
        rdy_d     = rdy_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_addr  = cpu_address;
        ram_wdata = cpu_writedata;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (jdo[JDO_CLR_RDY]) rdy_d = 1'b0;
                    if (jdo[JDO_CLR_ERR]) err_d = 1'b0;
                    // A simultaneous lower-priority pulse is lost; flag it even if clearing.
                    if (take_action_ocimem_b | take_no_action_ocimem_a) err_d = 1'b1;
                end else if (take_action_ocimem_b) begin
                    state_d = ST_WR;
                    rdy_d   = 1'b0;
                    wdata_d = jdo[JDO_WDATA_LSB +: DATA_W];
                    if (take_no_action_ocimem_a) err_d = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD_ADDR;
                    rdy_d   = 1'b0;
                end else if (cpu_grant) begin
                    ram_we = cpu_write;
                end
            end
            ST_RD_ADDR: begin
                ram_addr = mon_a_q;
                state_d  = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                mon_d_d = ram_q;
                mon_a_d = mon_a_q + 1'b1;
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR: begin
                ram_addr  = mon_a_q;
                ram_wdata = wdata_q;
                // A write interrupted by reset must not reach the array.
                ram_we    = ~reset;
                mon_a_d   = mon_a_q + 1'b1;
                rdy_d     = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (any_take && !host_idle) err_d = 1'b1;
    end

    // CPU read response: RAM output is valid one edge after acceptance,
    // then registered onto the port one edge later.
    always_comb begin
        rd_pend_d = cpu_grant & cpu_read;
        rdv_d     = rd_pend_q;
        rdata_d   = rd_pend_q ? ram_q : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mon_a_q   <= '0;
            mon_d_q   <= '0;
            wdata_q   <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mon_a_q   <= mon_a_d;
            mon_d_q   <= mon_d_d;
            wdata_q   <= wdata_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            rdv_q     <= rdv_d;
            rdata_q   <= rdata_d;
        end
    end

    nios_setup_nios2e_cpu_debug_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    assign cpu_readdata      = rdata_q;
    assign cpu_readdatavalid = rdv_q;
    assign MonDReg           = mon_d_q;
    assign monitor_ready     = rdy_q;
    assign monitor_error     = err_q;

endmodule

// File: tb/tb_nios_setup_nios2e_cpu_debug_ocimem.sv
module tb_nios_setup_nios2e_cpu_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_na, take_b;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid, cpu_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    nios_setup_nios2e_cpu_debug_ocimem #(.ADDR_W(8), .INIT_ZERO(1'b1)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t host_q[$];
    exp_t cpu_q[$];

    // Reference model: memory image, host address pointer, host data, error flag.
    logic [31:0] mem_m [256];
    logic [7:0]  addr_m;
    logic [31:0] dreg_m;
    logic        err_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every readdatavalid pulse and every rising monitor_ready pops one expectation.
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (cpu_readdatavalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL cpu_rdv_unexpected: got readdatavalid with data %h, expected none", cpu_readdata);
            end else begin
                e = cpu_q.pop_front();
                check("cpu_readdata", cpu_readdata, e.data);
                check("cpu_rdv_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (monitor_ready === 1'b1 && prev_rdy == 1'b0) begin
            if (host_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL host_ready_unexpected: got monitor_ready rise, expected none");
            end else begin
                e = host_q.pop_front();
                check("MonDReg", MonDReg, e.data);
                check("host_done_cycle", 32'(cyc), 32'(e.cyc));
                check("host_done_error", 32'(monitor_error), 32'(e.err));
            end
        end
        prev_rdy = (monitor_ready === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] rnd_jdo();
        logic [37:0] j;
        j[31:0]  = $urandom();
        j[37:32] = 6'($urandom());
        return j;
    endfunction

    task automatic host_a(input logic [7:0] a, input logic ce, input logic cr);
        logic [37:0] j;
        j = rnd_jdo();
        j[24:17] = a;
        j[35] = ce;
        j[34] = cr;
        jdo = j; take_a = 1'b1;
        step();
        take_a = 1'b0;
        addr_m = a;
        if (ce) err_m = 1'b0;
        check("host_a_error", 32'(monitor_error), 32'(err_m));
    endtask

    task automatic host_wr(input logic [31:0] d);
        logic [37:0] j;
        exp_t e;
        j = rnd_jdo();
        j[34:3] = d;
        e.cyc = cyc + 2;
        jdo = j; take_b = 1'b1;
        step();
        take_b = 1'b0;
        mem_m[addr_m] = d;
        addr_m++;
        e.data = dreg_m; e.err = err_m;
        host_q.push_back(e);
        step();
    endtask

    task automatic host_rd();
        exp_t e;
        e.cyc = cyc + 3;
        jdo = rnd_jdo(); take_na = 1'b1;
        step();
        take_na = 1'b0;
        dreg_m = mem_m[addr_m];
        addr_m++;
        e.data = dreg_m; e.err = err_m;
        host_q.push_back(e);
        step();
        step();
    endtask

    task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [31:0] d);
        int n;
        exp_t e;
        cpu_address = a; cpu_write = wr; cpu_read = ~wr; cpu_writedata = d;
        #1;
        n = 0;
        while (cpu_waitrequest === 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (cpu_waitrequest !== 1'b0) begin
            tests++; fails++;
            $display("FAIL cpu_accept_timeout: got waitrequest %b after %0d cycles, expected 0", cpu_waitrequest, n);
        end else if (wr) begin
            mem_m[a] = d;
        end else begin
            e.cyc = cyc + 2; e.data = mem_m[a]; e.err = 1'b0;
            cpu_q.push_back(e);
        end
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_read = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_MonDReg"}, MonDReg, 32'h0);
        check({tag, "_ready"}, 32'(monitor_ready), 32'h0);
        check({tag, "_error"}, 32'(monitor_error), 32'h0);
        check({tag, "_rdv"}, 32'(cpu_readdatavalid), 32'h0);
        check({tag, "_waitreq"}, 32'(cpu_waitrequest), 32'h0);
        check({tag, "_readdata"}, cpu_readdata, 32'h0);
    endtask

    task automatic model_reset();
        addr_m = 8'h00; dreg_m = 32'h0; err_m = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [37:0] j;
        int r;
        reset = 1'b1; jdo = '0; take_a = 0; take_na = 0; take_b = 0;
        cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
        model_reset();
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Give every word a known value.
        for (int a = 0; a < 256; a++) cpu_access(1'b1, 8'(a), $urandom());

        // Host write then readback; pointer post-increments.
        host_a(8'h10, 1'b0, 1'b0);
        host_wr(32'hDEADBEEF);
        host_rd();                       // reads 0x11
        host_a(8'h10, 1'b0, 1'b0);
        host_rd();                       // DEADBEEF

        // Pointer wraps from 0xFF to 0x00.
        host_a(8'hFF, 1'b0, 1'b0);
        host_wr(32'hA5A5_0FF0);
        host_rd();                       // reads 0x00
        host_a(8'hFF, 1'b0, 1'b0);
        host_rd();

        // Write pulse while a read is in flight: dropped, error sticks until cleared.
        host_a(8'h60, 1'b0, 1'b0);
        e.cyc = cyc + 3;
        jdo = rnd_jdo(); take_na = 1'b1;
        step();
        take_na = 1'b0;
        j = rnd_jdo(); j[34:3] = 32'hCAFEF00D;
        jdo = j; take_b = 1'b1;
        step();
        take_b = 1'b0;
        err_m = 1'b1;
        dreg_m = mem_m[addr_m]; addr_m++;
        e.data = dreg_m; e.err = 1'b1;
        host_q.push_back(e);
        step();
        check("drop_error_sticky", 32'(monitor_error), 32'h1);
        host_rd();                       // 0x61 untouched by the dropped write
        host_a(8'h60, 1'b1, 1'b0);       // clears error
        host_rd();

        // Same-cycle pulses: ocimem_a wins, write dropped, error set.
        j = rnd_jdo(); j[24:17] = 8'h50; j[35] = 1'b0;
        jdo = j; take_a = 1'b1; take_b = 1'b1;
        step();
        take_a = 1'b0; take_b = 1'b0;
        addr_m = 8'h50; err_m = 1'b1;
        check("prio_error", 32'(monitor_error), 32'h1);
        host_rd();
        host_a(8'h50, 1'b1, 1'b1);
        host_rd();

        // CPU write colliding with a host write: host first, CPU waits.
        host_a(8'h30, 1'b0, 1'b0);
        cpu_address = 8'h20; cpu_write = 1'b1; cpu_writedata = 32'h12345678;
        j = rnd_jdo(); j[34:3] = 32'h0BAD_C0DE;
        e.cyc = cyc + 2;
        jdo = j; take_b = 1'b1;
        #1;
        check("collide_waitreq", 32'(cpu_waitrequest), 32'h1);
        mem_m[addr_m] = 32'h0BAD_C0DE; addr_m++;
        e.data = dreg_m; e.err = err_m;
        host_q.push_back(e);
        @(posedge clk); #1;
        take_b = 1'b0;
        check("busy_waitreq", 32'(cpu_waitrequest), 32'h1);
        cpu_access(1'b1, 8'h20, 32'h12345678);
        cpu_access(1'b0, 8'h20, 32'h0);
        cpu_access(1'b0, 8'h30, 32'h0);

        // Reset while the host write is pending: nothing committed.
        host_a(8'h40, 1'b0, 1'b0);
        j = rnd_jdo(); j[34:3] = ~mem_m[8'h40];
        jdo = j; take_b = 1'b1;
        step();
        take_b = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check_reset_outputs("wr_reset");
        host_a(8'h40, 1'b0, 1'b0);
        host_rd();

        // Reset with a CPU read in flight: its valid pulse never appears.
        cpu_address = 8'h05; cpu_read = 1'b1;
        step();
        cpu_read = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        repeat (3) step();
        check_reset_outputs("rd_reset");
        cpu_access(1'b0, 8'h05, 32'h0);

        // Random mix of host and CPU operations.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: host_a(8'($urandom()), 1'($urandom()), 1'($urandom()));
                1: host_wr($urandom());
                2, 3: host_rd();
                4: cpu_access(1'b1, 8'($urandom()), $urandom());
                default: cpu_access(1'b0, 8'($urandom()), 32'h0);
            endcase
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (6) step();
        check("host_queue_drained", 32'(host_q.size()), 32'h0);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
